test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of monitored fetch channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32: fetch address width.
REQ-003 SHALL have parameter PASS_ADDR, default 32'h800001d4: fetch address that signals pass.
REQ-004 SHALL have parameter FAIL_ADDR, default 32'h800001b8: fetch address that signals fail.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 600: run cycles before timeout; CNT_W = clog2(TIMEOUT_CYCLES+1).
REQ-006 SHALL have parameter HANG_CYCLES, default 64: repeated-address count that counts as a hang.
REQ-007 SHALL have port: clock  input  1  single clock, rising edge.
REQ-008 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port: start  input  1  one-cycle pulse that begins a run.
REQ-010 SHALL have port: clear  input  1  synchronous return to IDLE.
REQ-011 SHALL have port: fetch_valid  input  NUM_CH  per-channel fetch request valid.
REQ-012 SHALL have port: fetch_addr  input  NUM_CH*ADDR_W  flattened fetch addresses; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port: ch_status  output  3*NUM_CH  per-channel state code.
REQ-014 SHALL have port: done  output  1  all channels terminal.
REQ-015 SHALL have port: all_pass  output  1  done and every channel PASS.
REQ-016 SHALL have port: done_cycle  output  CNT_W  cycle count latched when done rises.

Function
REQ-017 SHALL give each channel its own FSM with codes IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5.
REQ-018 SHALL move a channel from IDLE to RUN on the edge where start=1; start SHALL be ignored in any other state.
REQ-019 SHALL move a channel from RUN to PASS on the edge where fetch_valid[i]=1 and its address equals PASS_ADDR.
REQ-020 SHALL move a channel from RUN to FAIL on the edge where fetch_valid[i]=1 and its address equals FAIL_ADDR.
REQ-021 SHALL ignore addresses when fetch_valid[i]=0.
REQ-022 SHALL treat PASS, FAIL, TIMEOUT and HANG as sticky terminal states, left only by clear or reset.
REQ-023 SHALL keep a shared cycle counter: cleared on start, incremented each cycle while any channel is in RUN, saturating at TIMEOUT_CYCLES.
REQ-024 SHALL move every RUN channel to TIMEOUT on the edge where the counter equals TIMEOUT_CYCLES.
REQ-025 SHALL give a pass/fail match priority over timeout or hang detected in the same cycle; the match SHALL win.
REQ-026 SHALL give clear priority over start and over all transitions; clear sets every channel to IDLE and zeroes the counter, done_cycle and hang counters.
REQ-027 SHALL assert done combinationally from the registered states when every channel is terminal; done SHALL be 0 while any channel is IDLE or RUN.
REQ-028 SHALL load done_cycle with the counter value on the edge where done first becomes 1, and hold it until clear or reset.
REQ-029 SHALL assert all_pass only when done=1 and every ch_status equals PASS.
REQ-030 SHALL show a status change on ch_status one cycle after the triggering edge inputs; no combinational path from fetch inputs to outputs.

Reset
REQ-031 SHALL, while reset=0, immediately force: every ch_status=IDLE, counter=0, hang counters=0, done=0, all_pass=0, done_cycle=0.
REQ-032 SHALL abandon any run in progress when reset is asserted mid-run; after release, channels stay IDLE until start.

Configuration
REQ-033 SHALL use macro MONITOR_HANG_DETECT_EN to compile hang detection in or out.
REQ-034 SHALL, when MONITOR_HANG_DETECT_EN is defined, count consecutive valid fetches of the same address per channel in RUN, restart the count on an address change, and move the channel to HANG on the edge where the count reaches HANG_CYCLES.
REQ-035 SHALL, when MONITOR_HANG_DETECT_EN is undefined, contain no hang counters and never produce code 5.

Verification
REQ-036 SHALL test NUM_CH=1: start, then a valid fetch of 0x800001d4 at cycle 20 -> ch_status=2, done=1, all_pass=1, done_cycle=20.
REQ-037 SHALL test NUM_CH=2: ch0 fetches 0x800001d4 and ch1 fetches 0x800001b8 -> statuses 2 and 3, done=1, all_pass=0.
REQ-038 SHALL test TIMEOUT_CYCLES=600 with no match fetched -> every ch_status=4 at counter 600, done_cycle=600.
REQ-039 SHALL test a PASS_ADDR fetch in the same cycle the counter reaches 600 -> ch_status=2, not 4.
REQ-040 SHALL test MONITOR_HANG_DETECT_EN defined, HANG_CYCLES=64: 64 consecutive valid fetches of 0x80000100 -> ch_status=5; macro undefined -> the channel stays RUN until timeout.
REQ-041 SHALL test reset=0 mid-run at cycle 10, then clear during PASS -> all outputs return to 0/IDLE and a new start restarts the counter from 0.

Source files
------------

// File: rtl/test_status_monitor.sv
// Per-channel pass/fail/timeout monitor that watches instruction-fetch addresses after a start pulse.
// Optional hang detection (repeated-address run length) is compiled in with MONITOR_HANG_DETECT_EN.

package test_status_monitor_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } ch_state_e;
endpackage

module test_status_monitor_ch
  import test_status_monitor_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter     PASS_ADDR   = 32'h800001d4,
  parameter     FAIL_ADDR   = 32'h800001b8,
  parameter int HANG_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_go,
  input  logic              timeout_hit,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [2:0]        st_cur,
  output logic [2:0]        st_nxt
);
  localparam logic [ADDR_W-1:0] PASS_A = ADDR_W'(PASS_ADDR);
  localparam logic [ADDR_W-1:0] FAIL_A = ADDR_W'(FAIL_ADDR);

  ch_state_e st_q, st_d;
  logic      pass_hit, fail_hit, hang_hit;

  assign pass_hit = fetch_valid && (fetch_addr == PASS_A);
  assign fail_hit = fetch_valid && (fetch_addr == FAIL_A);

`ifdef MONITOR_HANG_DETECT_EN
  localparam int HC_W = $clog2(HANG_CYCLES + 1);

  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [ADDR_W-1:0] last_q;

  // Run length of identical valid fetch addresses; a new address restarts at 1.
  always_comb begin
    hcnt_d = hcnt_q;
    if (fetch_valid)
      hcnt_d = (hcnt_q != '0 && fetch_addr == last_q) ? hcnt_q + 1'b1 : HC_W'(1);
  end

  assign hang_hit = (st_q == ST_RUN) && fetch_valid && (hcnt_d == HC_W'(HANG_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt_q <= '0;
      last_q <= '0;
    end else if (clear || st_q != ST_RUN) begin
      hcnt_q <= '0;
      last_q <= '0;
    end else if (fetch_valid) begin
      hcnt_q <= hcnt_d;
      last_q <= fetch_addr;
    end
  end
`else
  assign hang_hit = 1'b0;
`endif

  // A pass/fail match outranks timeout and hang seen on the same edge.
  always_comb begin
    st_d = st_q;
    if (clear) st_d = ST_IDLE;
    else begin
      case (st_q)
        ST_IDLE: if (start_go) st_d = ST_RUN;
        ST_RUN: begin
          if (pass_hit)         st_d = ST_PASS;
          else if (fail_hit)    st_d = ST_FAIL;
          else if (timeout_hit) st_d = ST_TIMEOUT;
          else if (hang_hit)    st_d = ST_HANG;
        end
        default: st_d = st_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  assign st_cur = st_q;
  assign st_nxt = st_d;
endmodule

module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int ADDR_W         = 32,
  parameter     PASS_ADDR      = 32'h800001d4,
  parameter     FAIL_ADDR      = 32'h800001b8,
  parameter int TIMEOUT_CYCLES = 600,
  parameter int HANG_CYCLES    = 64,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        fetch_valid,
  input  logic [NUM_CH*ADDR_W-1:0] fetch_addr,
  output logic [3*NUM_CH-1:0]      ch_status,
  output logic                     done,
  output logic                     all_pass,
  output logic [CNT_W-1:0]         done_cycle
);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic [NUM_CH-1:0][2:0] st, st_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic                   any_idle, any_run, done_nxt, pass_all, start_go, timeout_hit;

  function automatic logic is_term(input logic [2:0] s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
  endfunction

  always_comb begin
    any_idle = 1'b0;
    any_run  = 1'b0;
    done     = 1'b1;
    done_nxt = 1'b1;
    pass_all = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      any_idle |= (st[i] == ST_IDLE);
      any_run  |= (st[i] == ST_RUN);
      done     &= is_term(st[i]);
      done_nxt &= is_term(st_nxt[i]);
      pass_all &= (st[i] == ST_PASS);
    end
  end

  assign all_pass    = done && pass_all;
  assign start_go    = start && any_idle && !clear;
  assign timeout_hit = (cnt_q == TO_CNT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    test_status_monitor_ch #(
      .ADDR_W     (ADDR_W),
      .PASS_ADDR  (PASS_ADDR),
      .FAIL_ADDR  (FAIL_ADDR),
      .HANG_CYCLES(HANG_CYCLES)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .start_go   (start_go),
      .timeout_hit(timeout_hit),
      .fetch_valid(fetch_valid[i]),
      .fetch_addr (fetch_addr[i*ADDR_W +: ADDR_W]),
      .st_cur     (st[i]),
      .st_nxt     (st_nxt[i])
    );
    assign ch_status[i*3 +: 3] = st[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          cnt_q <= '0;
    else if (clear || start_go)          cnt_q <= '0;
    else if (any_run && cnt_q != TO_CNT) cnt_q <= cnt_q + 1'b1;
  end

  // Capture the count seen on the edge that makes the last channel terminal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                done_cycle <= '0;
    else if (clear)            done_cycle <= '0;
    else if (done_nxt && !done) done_cycle <= cnt_q;
  end
endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench: one 1-channel and one 2-channel monitor driven through pass, fail,
// timeout, match-vs-timeout priority, hang (macro dependent), clear and mid-run reset.
module tb_test_status_monitor;
  localparam logic [31:0] PASS_A = 32'h800001d4;
  localparam logic [31:0] FAIL_A = 32'h800001b8;
  localparam logic [31:0] LOOP_A = 32'h80000100;
  localparam logic [31:0] OTHR_A = 32'h80000200;

  logic        clock, reset;
  logic        start1, clear1, start2, clear2;
  logic [0:0]  fv1;
  logic [31:0] fa1;
  logic [2:0]  cs1;
  logic        done1, ap1;
  logic [9:0]  dc1;
  logic [1:0]  fv2;
  logic [63:0] fa2;
  logic [5:0]  cs2;
  logic        done2, ap2;
  logic [9:0]  dc2;

  int n_cmp = 0;
  int n_err = 0;

  test_status_monitor #(.NUM_CH(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .clear(clear1),
    .fetch_valid(fv1), .fetch_addr(fa1), .ch_status(cs1),
    .done(done1), .all_pass(ap1), .done_cycle(dc1)
  );

  test_status_monitor #(.NUM_CH(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .clear(clear2),
    .fetch_valid(fv2), .fetch_addr(fa2), .ch_status(cs2),
    .done(done2), .all_pass(ap2), .done_cycle(dc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start1();
    start1 = 1'b1; tick(); start1 = 1'b0;
  endtask

  task automatic pulse_clear1();
    clear1 = 1'b1; tick(); clear1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start1 = 0; clear1 = 0; start2 = 0; clear2 = 0;
    fv1 = '0; fa1 = '0; fv2 = '0; fa2 = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_cs1", 32'(cs1), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_ap1", 32'(ap1), 0);
    chk("rst_dc1", 32'(dc1), 0);
    chk("rst_cs2", 32'(cs2), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_no_start", 32'(cs1), 0);

    // single channel pass at count 20; address without valid is ignored
    pulse_start1();
    chk("run_cs1", 32'(cs1), 1);
    chk("run_done1", 32'(done1), 0);
    fa1 = PASS_A;
    repeat (20) tick();
    chk("novalid_ignored", 32'(cs1), 1);
    fv1 = 1'b1; tick(); fv1 = 1'b0;
    chk("pass_cs1", 32'(cs1), 2);
    chk("pass_done1", 32'(done1), 1);
    chk("pass_ap1", 32'(ap1), 1);
    chk("pass_dc1", 32'(dc1), 20);
    fa1 = FAIL_A; fv1 = 1'b1; start1 = 1'b1; tick(); fv1 = 1'b0; start1 = 1'b0;
    chk("pass_sticky", 32'(cs1), 2);

    // clear from PASS, then restart: counter starts over from 0
    pulse_clear1();
    chk("clr_cs1", 32'(cs1), 0);
    chk("clr_done1", 32'(done1), 0);
    chk("clr_ap1", 32'(ap1), 0);
    chk("clr_dc1", 32'(dc1), 0);
    pulse_start1();
    fa1 = PASS_A; fv1 = 1'b1; tick(); fv1 = 1'b0;
    chk("restart_dc1", 32'(dc1), 0);
    chk("restart_cs1", 32'(cs1), 2);

    // two channels: ch0 pass, then ch1 fail
    start2 = 1'b1; tick(); start2 = 1'b0;
    fa2[31:0] = PASS_A; fv2 = 2'b01; tick(); fv2 = 2'b00;
    chk("mix_partial_cs2", 32'(cs2), 32'o12);
    chk("mix_partial_done2", 32'(done2), 0);
    fa2[63:32] = FAIL_A; fv2 = 2'b10; tick(); fv2 = 2'b00;
    chk("mix_cs2", 32'(cs2), 32'o32);
    chk("mix_done2", 32'(done2), 1);
    chk("mix_ap2", 32'(ap2), 0);
    chk("mix_dc2", 32'(dc2), 1);

    // timeout with no match
    pulse_clear1();
    pulse_start1();
    repeat (600) tick();
    chk("to_edge_run", 32'(cs1), 1);
    chk("to_edge_done", 32'(done1), 0);
    tick();
    chk("to_cs1", 32'(cs1), 4);
    chk("to_dc1", 32'(dc1), 600);
    chk("to_done1", 32'(done1), 1);
    chk("to_ap1", 32'(ap1), 0);

    // pass match on the timeout edge wins; other channel times out
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (600) tick();
    fa2[31:0] = PASS_A; fv2 = 2'b01; tick(); fv2 = 2'b00;
    chk("prio_cs2", 32'(cs2), 32'o42);
    chk("prio_dc2", 32'(dc2), 600);
    chk("prio_done2", 32'(done2), 1);

    // repeated address: hang when compiled in, else timeout
    pulse_clear1();
    pulse_start1();
    fv1 = 1'b1; fa1 = OTHR_A;
    repeat (10) tick();
    fa1 = LOOP_A;
    repeat (63) tick();
    chk("hang_pre", 32'(cs1), 1);
    tick();
    fv1 = 1'b0;
`ifdef MONITOR_HANG_DETECT_EN
    chk("hang_cs1", 32'(cs1), 5);
    chk("hang_dc1", 32'(dc1), 73);
    chk("hang_done1", 32'(done1), 1);
`else
    chk("nohang_cs1", 32'(cs1), 1);
    repeat (526) tick();
    chk("nohang_still_run", 32'(cs1), 1);
    tick();
    chk("nohang_to_cs1", 32'(cs1), 4);
    chk("nohang_to_dc1", 32'(dc1), 600);
`endif

    // asynchronous reset mid-run abandons everything
    pulse_clear1();
    pulse_start1();
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("mrst_cs1", 32'(cs1), 0);
    chk("mrst_done1", 32'(done1), 0);
    chk("mrst_cs2", 32'(cs2), 0);
    chk("mrst_done2", 32'(done2), 0);
    chk("mrst_dc2", 32'(dc2), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("mrst_stay_idle", 32'(cs1), 0);
    pulse_start1();
    repeat (3) tick();
    fa1 = PASS_A; fv1 = 1'b1; tick(); fv1 = 1'b0;
    chk("mrst_restart_cs1", 32'(cs1), 2);
    chk("mrst_restart_dc1", 32'(dc1), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
